// File: rtl/edge_gen.sv
// Edge generator: turns rise/fall request pulses into a level waveform.
// Each level is held a programmable minimum time, and early requests wait in a per-channel counter.
module edge_gen #(
   parameter int   DATA_WIDTH = 1,
   parameter int   CNT_WIDTH  = 8,
   parameter int   MAX_PEND   = 4,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] re_i,
   input  logic [DATA_WIDTH-1:0] fe_i,
   input  logic [CNT_WIDTH-1:0]  hold_i,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic [DATA_WIDTH-1:0] busy_o,
   output logic [DATA_WIDTH-1:0] drop_o,
   output logic [DATA_WIDTH-1:0] ovf_o
);

   // state | meaning
   // IDLE  | no hold in progress, an edge may be emitted immediately
   // HOLD  | level held, cnt counts down the remaining hold cycles
   typedef enum logic {IDLE, HOLD} state_t;

   localparam int PEND_W = $clog2(MAX_PEND + 1);
   localparam int SUM_W  = PEND_W + 2;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
      state_t               state_q, state_d;
      logic                 dat_q, dat_d;
      logic                 busy_q, busy_d;
      logic                 drop_q, drop_d;
      logic                 ovf_q, ovf_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic [PEND_W-1:0]    pend_q, pend_d;
      logic                 proj;
      logic                 window;
      logic                 emit;
      logic [1:0]           acc;
      logic [1:0]           kept;
      logic [SUM_W-1:0]     room;
      logic [SUM_W-1:0]     pend_sum;

      always_comb begin
         proj     = dat_q ^ pend_q[0];
         acc      = 2'd0;
         drop_d   = 1'b0;
         if (re_i[i] && fe_i[i]) begin
            acc = 2'd2;
         end else if (re_i[i]) begin
            if (!proj) acc = 2'd1;
            else       drop_d = 1'b1;
         end else if (fe_i[i]) begin
            if (proj)  acc = 2'd1;
            else       drop_d = 1'b1;
         end

         window = (state_q == IDLE) || (cnt_q == '0);
         emit   = window && ((pend_q != '0) || (acc != 2'd0));

         // Queue slots left after this cycle's emit; excess accepted requests are lost.
         room     = SUM_W'(MAX_PEND) - SUM_W'(pend_q) + SUM_W'(emit);
         kept     = (SUM_W'(acc) > room) ? room[1:0] : acc;
         ovf_d    = (kept != acc);
         pend_sum = SUM_W'(pend_q) + SUM_W'(kept) - SUM_W'(emit);
         pend_d   = pend_sum[PEND_W-1:0];

         dat_d    = dat_q;
         cnt_d    = cnt_q;
         state_d  = state_q;
         if (emit) begin
            dat_d   = ~dat_q;
            cnt_d   = (hold_i == '0) ? '0 : hold_i - CNT_WIDTH'(1);
            state_d = HOLD;
         end else if (state_q == HOLD) begin
            if (cnt_q != '0) cnt_d   = cnt_q - CNT_WIDTH'(1);
            else             state_d = IDLE;
         end

         busy_d = (pend_d != '0) || ((state_d == HOLD) && (cnt_d != '0));
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q <= IDLE;
            dat_q   <= RST_VAL;
            cnt_q   <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
         end
      end

      assign dat_o[i]  = dat_q;
      assign busy_o[i] = busy_q;
      assign drop_o[i] = drop_q;
      assign ovf_o[i]  = ovf_q;
   end

endmodule
